pu_riscv_pfpu64_cnv_ctrl: RTL and testbench

Sequencer and arbiter for the pfpu64 int-to-float conversion pipeline (i2f stage plus the downstream normalize and round stages).
- Accepts conversion requests from NREQ requesters over valid/ready handshakes and grants one per advance cycle, round-robin.
- Drives the pipe's advance, start, flush and operand inputs.
- Tracks requester id and tag through the fixed-depth pipe and presents the result-side handshake with back-pressure.

---
 rtl/pu_riscv_pfpu64_pkg.sv | 15 +
 rtl/pu_riscv_rr_arbiter.sv | 29 ++
 rtl/pu_riscv_pfpu64_cnv_ctrl.sv | 122 ++++++++++++
 tb/tb_pu_riscv_pfpu64_cnv_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pu_riscv_pfpu64_pkg.sv
// Shared types and constants for the pfpu64 int-to-float conversion control path.
// Slot fields are sized for the widest supported configuration; users slice down.
package pu_riscv_pfpu64_pkg;

    localparam int PFPU64_CNV_DEPTH = 3;
    localparam int CNV_IDW_MAX      = 2;
    localparam int CNV_TAGW_MAX     = 16;

    typedef struct packed {
        logic                    v;
        logic [CNV_IDW_MAX-1:0]  id;
        logic [CNV_TAGW_MAX-1:0] tag;
    } cnv_slot_t;

endpackage

// File: rtl/pu_riscv_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr_i, wrapping.
// Produces a one-hot grant, or zero when disabled or nothing is requested.
module pu_riscv_rr_arbiter #(
    parameter int  NREQ = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o
);

    logic found;
    int   idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (en_i && !found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pu_riscv_pfpu64_cnv_ctrl.sv
// Sequencer/arbiter for the pfpu64 i2f conversion pipe: grants requests round-robin,
// tracks id/tag through the fixed-depth pipe and presents the result handshake.
module pu_riscv_pfpu64_cnv_ctrl
    import pu_riscv_pfpu64_pkg::*;
#(
    parameter int  NREQ  = 2,
    parameter int  DEPTH = PFPU64_CNV_DEPTH,
    parameter int  TAGW  = 5,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*64-1:0]   req_opa_i,
    input  logic [NREQ*TAGW-1:0] req_tag_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 cnv_adv_o,
    output logic                 cnv_flush_o,
    output logic                 cnv_start_o,
    output logic [63:0]          cnv_opa_o,
    input  logic                 cnv_rdy_i,
    output logic                 res_valid_o,
    output logic [IDW-1:0]       res_id_o,
    output logic [TAGW-1:0]      res_tag_o,
    input  logic                 res_ready_i,
    output logic                 busy_o,
    output logic                 err_o
);

    cnv_slot_t        slot_q [DEPTH];
    cnv_slot_t        slot_d [DEPTH];
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             err_q, err_d;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   win_id;
    logic [TAGW-1:0]  win_tag;
    logic             head_v;
    logic             unused_slot_bits;

    assign head_v      = slot_q[DEPTH-1].v;
    assign cnv_adv_o   = (!head_v | res_ready_i) & !flush_i & rst;
    assign cnv_flush_o = flush_i | !rst;
    assign req_ready_o = gnt;
    assign cnv_start_o = |gnt;

    pu_riscv_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .en_i  (cnv_adv_o),
        .gnt_o (gnt)
    );

    always_comb begin
        win_id    = '0;
        win_tag   = '0;
        cnv_opa_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_id    = IDW'(i);
                win_tag   = req_tag_i[TAGW*i +: TAGW];
                cnv_opa_o = req_opa_i[64*i +: 64];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (cnv_start_o) begin
            rr_ptr_d = (int'(win_id) == NREQ-1) ? '0 : win_id + 1'b1;
        end
    end

    // Flush drops every entry, including a result the consumer has not taken yet.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            slot_d[k] = slot_q[k];
        end
        if (flush_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_d[k].v = 1'b0;
            end
        end else if (cnv_adv_o) begin
            for (int k = 1; k < DEPTH; k++) begin
                slot_d[k] = slot_q[k-1];
            end
            slot_d[0].v   = cnv_start_o;
            slot_d[0].id  = CNV_IDW_MAX'(win_id);
            slot_d[0].tag = CNV_TAGW_MAX'(win_tag);
        end
    end

    assign err_d = err_q | (!flush_i & (cnv_rdy_i != head_v));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            busy_o = busy_o | slot_q[k].v;
        end
    end

    assign res_valid_o      = head_v;
    assign res_id_o         = slot_q[DEPTH-1].id[IDW-1:0];
    assign res_tag_o        = slot_q[DEPTH-1].tag[TAGW-1:0];
    assign err_o            = err_q;
    assign unused_slot_bits = ^{slot_q[DEPTH-1].id, slot_q[DEPTH-1].tag};

endmodule

// File: tb/tb_pu_riscv_pfpu64_cnv_ctrl.sv
// Bench for pu_riscv_pfpu64_cnv_ctrl: directed scenarios plus random traffic,
// checked against a queue-based model of in-flight conversions.
module tb_pu_riscv_pfpu64_cnv_ctrl;

    localparam int NREQ  = 2;
    localparam int DEPTH = 3;
    localparam int TAGW  = 5;
    localparam int IDW   = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush_i;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ*64-1:0]   req_opa_i;
    logic [NREQ*TAGW-1:0] req_tag_i;
    logic [NREQ-1:0]      req_ready_o;
    logic                 cnv_adv_o, cnv_flush_o, cnv_start_o;
    logic [63:0]          cnv_opa_o;
    logic                 cnv_rdy_i;
    logic                 res_valid_o;
    logic [IDW-1:0]       res_id_o;
    logic [TAGW-1:0]      res_tag_o;
    logic                 res_ready_i;
    logic                 busy_o, err_o;

    always #5 clk = ~clk;

    pu_riscv_pfpu64_cnv_ctrl #(.NREQ(NREQ), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_opa_i(req_opa_i), .req_tag_i(req_tag_i),
        .req_ready_o(req_ready_o), .cnv_adv_o(cnv_adv_o), .cnv_flush_o(cnv_flush_o),
        .cnv_start_o(cnv_start_o), .cnv_opa_o(cnv_opa_o), .cnv_rdy_i(cnv_rdy_i),
        .res_valid_o(res_valid_o), .res_id_o(res_id_o), .res_tag_o(res_tag_o),
        .res_ready_i(res_ready_i), .busy_o(busy_o), .err_o(err_o)
    );

    // In-flight conversions, oldest first; pos counts advances since the grant.
    typedef struct {
        int id;
        int tag;
        int pos;
    } ent_t;

    ent_t q[$];
    int   m_ptr;
    bit   m_err;
    bit   rdy_ovr;
    int   last_win;
    int   checks;
    int   errors;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input bit v, input logic [63:0] opa, input logic [TAGW-1:0] tag);
        req_valid_i[i]            = v;
        req_opa_i[64*i +: 64]     = opa;
        req_tag_i[TAGW*i +: TAGW] = tag;
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic cycle();
        bit          hv;
        bit          adv;
        int          win;
        logic [63:0] exp_opa;
        hv        = (q.size() > 0) && (q[0].pos == DEPTH-1);
        cnv_rdy_i = rdy_ovr ? 1'b1 : hv;
        adv       = rst && !flush_i && (!hv || res_ready_i);
        win       = -1;
        if (adv) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (win < 0 && req_valid_i[idx]) win = idx;
            end
        end
        exp_opa = (win >= 0) ? req_opa_i[64*win +: 64] : 64'd0;
        #1;
        chk("req_ready", 64'(req_ready_o), (win >= 0) ? (64'd1 << win) : 64'd0);
        chk("cnv_adv", 64'(cnv_adv_o), 64'(adv));
        chk("cnv_flush", 64'(cnv_flush_o), 64'(!rst || flush_i));
        chk("cnv_start", 64'(cnv_start_o), 64'(win >= 0));
        chk("cnv_opa", cnv_opa_o, exp_opa);
        chk("res_valid", 64'(res_valid_o), 64'(hv));
        if (hv) begin
            chk("res_id", 64'(res_id_o), 64'(q[0].id));
            chk("res_tag", 64'(res_tag_o), 64'(q[0].tag));
        end
        chk("busy", 64'(busy_o), 64'(q.size() > 0));
        chk("err", 64'(err_o), 64'(m_err));
        @(posedge clk);
        if (!rst) begin
            q.delete();
            m_ptr = 0;
            m_err = 1'b0;
        end else begin
            if (!flush_i && (cnv_rdy_i != hv)) m_err = 1'b1;
            if (flush_i) begin
                q.delete();
            end else if (adv) begin
                if (hv) void'(q.pop_front());
                foreach (q[j]) q[j].pos++;
                if (win >= 0) begin
                    q.push_back('{id: win, tag: int'(req_tag_i[TAGW*win +: TAGW]), pos: 0});
                    m_ptr = (win + 1) % NREQ;
                end
            end
        end
        last_win = win;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush_i     = 1'b0;
        res_ready_i = 1'b1;
        req_valid_i = '0;
        req_opa_i   = '0;
        req_tag_i   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        int t2_exp[4];
        t2_exp   = '{0, 1, 0, 1};
        checks   = 0;
        errors   = 0;
        m_ptr    = 0;
        m_err    = 1'b0;
        rdy_ovr  = 1'b0;
        last_win = -1;
        cnv_rdy_i = 1'b0;
        rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        cycle();
        rst = 1'b1;

        // Single request with a negative operand
        set_req(0, 1'b1, -64'sd5, 5'd7);
        #1;
        chk("t1_ready", 64'(req_ready_o), 64'd1);
        chk("t1_opa", cnv_opa_o, 64'hFFFF_FFFF_FFFF_FFFB);
        cycle();
        req_valid_i = '0;
        cycle();
        cycle();
        #1;
        chk("t1_res_valid", 64'(res_valid_o), 64'd1);
        chk("t1_res_id", 64'(res_id_o), 64'd0);
        chk("t1_res_tag", 64'(res_tag_o), 64'd7);
        cycle();
        cycle();

        // Two requesters valid continuously from rr_ptr=0
        do_reset();
        set_req(0, 1'b1, 64'd100, 5'd1);
        set_req(1, 1'b1, 64'd200, 5'd2);
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (i < 4) chk("t2_grant", 64'(last_win), 64'(t2_exp[i]));
        end

        // Back-pressure, then release
        res_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("t3_stall_busy", 64'(busy_o), 64'd1);
        res_ready_i = 1'b1;
        cycle();
        chk("t3_release_grant", 64'(last_win >= 0), 64'd1);

        // Flush with an unconsumed result
        res_ready_i = 1'b0;
        cycle();
        cycle();
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        #1;
        chk("t4_busy", 64'(busy_o), 64'd0);
        chk("t4_res_valid", 64'(res_valid_o), 64'd0);
        res_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Reset mid-stream
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        #1;
        chk("t5_busy", 64'(busy_o), 64'd0);
        chk("t5_err", 64'(err_o), 64'd0);
        for (int i = 0; i < 4; i++) cycle();

        // Ready flag disagreeing with an empty pipe
        do_reset();
        rdy_ovr = 1'b1;
        cycle();
        rdy_ovr = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("t6_err_sticky", 64'(err_o), 64'd1);
        do_reset();
        #1;
        chk("t6_err_cleared", 64'(err_o), 64'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (last_win == i || !req_valid_i[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(i, 1'b1, {$urandom, $urandom}, TAGW'($urandom_range(0, 31)));
                    else
                        req_valid_i[i] = 1'b0;
                end
            end
            res_ready_i = ($urandom_range(0, 3) != 0);
            flush_i     = ($urandom_range(0, 29) == 0);
            rst         = ($urandom_range(0, 59) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
